acq_window_sequencer: RTL and testbench
=======================================

Name: acq_window_sequencer

Overview:
- Sequences one triggered acquisition: start, pre-trigger fill, armed, post-trigger capture, done.
- Sits between the sample stream/trigger detector and the DMA write master.
- Writes samples into a circular buffer in memory and reports the trigger index and window start index to HPS registers, so software can read the window linearly.

Parameters:
DATA_WIDTH, 16, sample width in bits; a multiple of 8
MEMORY_ADDR_LEN, 32, DMA address width
CNT_WIDTH, 16, width of the length, count and index fields

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  HPS pulse: latch config and begin acquisition
abort  in  1  HPS pulse: return to IDLE
base_addr  in  MEMORY_ADDR_LEN  buffer byte base address
buf_len  in  CNT_WIDTH  buffer size in samples
pre_count  in  CNT_WIDTH  pre-trigger samples
post_count  in  CNT_WIDTH  post-trigger samples, trigger sample included
in_data_valid  in  1  sample strobe
in_data  in  DATA_WIDTH  sample
trig_in  in  1  trigger detector output, qualified with in_data_valid
out_valid  out  1  write request to DMA
out_ready  in  1  DMA accepts
out_data  out  DATA_WIDTH  sample to write
out_addr  out  MEMORY_ADDR_LEN  byte address of the write
trig_index  out  CNT_WIDTH  buffer index of the trigger sample
win_start  out  CNT_WIDTH  buffer index of the first window sample
busy  out  1  high in PRE, ARMED and POST
done  out  1  acquisition complete; held until start, abort or rst
cfg_error  out  1  sticky; set on an illegal config at start
overflow  out  1  sticky; set when a sample is dropped

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr, pre_cnt and post_cnt 0.
- States are IDLE, PRE, ARMED, POST, DONE.
- Start handling:
  - start in IDLE or DONE latches all configuration inputs and clears done, overflow and cfg_error.
  - Config is illegal if buf_len==0 or pre_count+post_count > buf_len (compare at CNT_WIDTH+1 bits).
  - Illegal config: set cfg_error and stay in IDLE.
  - Legal config: go to PRE, or directly to ARMED if pre_count==0.
  - start in PRE, ARMED or POST is ignored.
- Abort:
  - abort has priority over everything; next cycle state is IDLE, busy=0, done=0.
  - abort and start in the same cycle resolve as abort.
- Accepted sample: in_data_valid=1 in PRE, ARMED or POST, and the output register is free (out_valid=0, or out_ready=1 this cycle).
- Each accepted sample:
  - Registered into out_data, with out_addr = base_addr + wr_ptr*(DATA_WIDTH/8); out_valid=1 on the next cycle (latency 1).
  - wr_ptr increments and wraps from buf_len-1 to 0.
  - out_valid is held until out_ready; out_data and out_addr stay stable while out_valid && !out_ready.
- Dropped sample: in_data_valid while the output register is blocked. Set overflow and drop the sample; wr_ptr and all counters are unchanged.
- PRE:
  - trig_in is ignored.
  - pre_cnt increments per accepted sample; at pre_cnt==pre_count go to ARMED, on the same edge as the last pre sample.
- ARMED:
  - Samples keep writing circularly.
  - An accepted sample with trig_in=1 sets trig_index=wr_ptr of that sample and win_start=(wr_ptr - pre_count) mod buf_len, sets post_cnt=1, and moves to POST.
  - If post_count<=1, go straight to DONE.
- POST: each accepted sample increments post_cnt; trig_in is ignored. Reaching post_cnt==post_count moves to DONE.
- DONE:
  - No new samples accepted; a pending out_valid still drains.
  - done=1 and busy=0.
- Arithmetic:
  - Index math is modulo buf_len, done with compare/subtract and no divider.
  - Address math is at MEMORY_ADDR_LEN bits with wrap ignored.
- Counter invariants: pre_cnt saturates at pre_count; post_cnt never exceeds post_count.

Decomposition:
- Shared package acq_pkg holds:
  - state encoding constants: ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_DONE;
  - BYTES_PER_SAMPLE = DATA_WIDTH/8.
- One natural sub-module, circ_addr_gen:
  - contains wr_ptr, the wrap logic and the modulo subtract for win_start;
  - produces the byte address.
- The FSM and the output register stay in the top module.

Test Plan:
- Normal run: buf_len=16, pre=4, post=4, out_ready=1, trigger on sample 10 -> trig_index=9, win_start=5, exactly 13 writes at base+0..base+24 step 2, done=1.
- Wrap: buf_len=8, pre=3, post=3, trigger on sample 20 -> out_addr wraps past base+14 to base+0; trig_index=3, win_start=0.
- Trigger during PRE: pre=4, trig_in high on samples 1-3 then low, then high on sample 6 -> only sample 6 triggers.
- Backpressure: hold out_ready=0 for 3 cycles with continuous valid -> overflow=1, dropped samples not counted, out_data/out_addr stable while stalled.
- Config error: buf_len=8, pre=5, post=4 -> cfg_error=1, stays IDLE, no out_valid. Also pre=0, post=1 -> DONE right after the first triggered sample.
- Abort/reset: abort in POST -> IDLE next cycle, done=0. rst mid-PRE -> all outputs 0. start and abort in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared definitions for the triggered acquisition sequencer: state encoding
// and sample-size helpers used by the top and the circular address generator.
package acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } acq_state_t;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int BYTES_PER_SAMPLE   = DEFAULT_DATA_WIDTH / 8;

   function automatic int bytes_per_sample(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/circ_addr_gen.sv
// Circular write pointer over a buffer of buf_len samples, the byte address of
// the current slot, and the window start index (wr_ptr - pre_count) mod buf_len.
module circ_addr_gen
   import acq_pkg::*;
#(
   parameter int MEMORY_ADDR_LEN = 32,
   parameter int CNT_WIDTH       = 16,
   parameter int BYTES           = BYTES_PER_SAMPLE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       advance,
   input  logic [CNT_WIDTH-1:0]       buf_len,
   input  logic [CNT_WIDTH-1:0]       pre_count,
   input  logic [MEMORY_ADDR_LEN-1:0] base_addr,
   output logic [CNT_WIDTH-1:0]       wr_ptr,
   output logic [CNT_WIDTH-1:0]       win_start_calc,
   output logic [MEMORY_ADDR_LEN-1:0] addr
);

   logic [CNT_WIDTH-1:0] wr_ptr_reg;
   logic [CNT_WIDTH-1:0] wr_ptr_next;
   logic [CNT_WIDTH:0]   ptr_inc;

   assign ptr_inc = {1'b0, wr_ptr_reg} + {{CNT_WIDTH{1'b0}}, 1'b1};

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      if (clear) begin
         wr_ptr_next = '0;
      end else if (advance) begin
         wr_ptr_next = (ptr_inc >= {1'b0, buf_len}) ? '0 : ptr_inc[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
      end
   end

   // When the pointer is behind pre_count, adding buf_len first keeps the
   // true result below buf_len, so modulo-2^CNT_WIDTH arithmetic is exact.
   assign win_start_calc = (wr_ptr_reg >= pre_count) ? (wr_ptr_reg - pre_count)
                                                     : (wr_ptr_reg + buf_len - pre_count);

   assign addr   = base_addr + MEMORY_ADDR_LEN'(wr_ptr_reg) * MEMORY_ADDR_LEN'(BYTES);
   assign wr_ptr = wr_ptr_reg;

endmodule

// File: rtl/acq_window_sequencer.sv
// One triggered acquisition: pre-trigger fill, armed wait, post-trigger capture,
// writing samples into a circular DMA buffer and reporting the window indices.
module acq_window_sequencer
   import acq_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int MEMORY_ADDR_LEN = 32,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [MEMORY_ADDR_LEN-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]       buf_len,
   input  logic [CNT_WIDTH-1:0]       pre_count,
   input  logic [CNT_WIDTH-1:0]       post_count,
   input  logic                       in_data_valid,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic                       trig_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [MEMORY_ADDR_LEN-1:0] out_addr,
   output logic [CNT_WIDTH-1:0]       trig_index,
   output logic [CNT_WIDTH-1:0]       win_start,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_error,
   output logic                       overflow
);

   localparam int BPS = bytes_per_sample(DATA_WIDTH);

   acq_state_t state_reg, state_next;

   logic [MEMORY_ADDR_LEN-1:0] base_reg, base_next;
   logic [CNT_WIDTH-1:0]       len_reg, len_next;
   logic [CNT_WIDTH-1:0]       pre_reg, pre_next;
   logic [CNT_WIDTH-1:0]       post_reg, post_next;
   logic [CNT_WIDTH-1:0]       pre_cnt_reg, pre_cnt_next;
   logic [CNT_WIDTH-1:0]       post_cnt_reg, post_cnt_next;
   logic [CNT_WIDTH-1:0]       trig_index_reg, trig_index_next;
   logic [CNT_WIDTH-1:0]       win_start_reg, win_start_next;
   logic                       done_reg, done_next;
   logic                       cfg_error_reg, cfg_error_next;
   logic                       overflow_reg, overflow_next;

   logic                       out_valid_reg;
   logic [DATA_WIDTH-1:0]      out_data_reg;
   logic [MEMORY_ADDR_LEN-1:0] out_addr_reg;

   logic                       active;
   logic                       slot_free;
   logic                       accept;
   logic                       drop;
   logic                       start_ok;
   logic                       cfg_bad;
   logic [CNT_WIDTH:0]         win_sum;
   logic [CNT_WIDTH-1:0]       wr_ptr;
   logic [CNT_WIDTH-1:0]       win_start_calc;
   logic [MEMORY_ADDR_LEN-1:0] wr_addr;

   assign active    = (state_reg == ST_PRE) || (state_reg == ST_ARMED) || (state_reg == ST_POST);
   assign slot_free = !out_valid_reg || out_ready;
   assign accept    = active && in_data_valid && slot_free && !abort;
   assign drop      = active && in_data_valid && !slot_free && !abort;
   assign start_ok  = start && !abort && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   // Sum compared one bit wider so pre+post cannot wrap past buf_len.
   assign win_sum = {1'b0, pre_count} + {1'b0, post_count};
   assign cfg_bad = (buf_len == '0) || (win_sum > {1'b0, buf_len});

   circ_addr_gen #(
      .MEMORY_ADDR_LEN (MEMORY_ADDR_LEN),
      .CNT_WIDTH       (CNT_WIDTH),
      .BYTES           (BPS)
   ) u_addr (
      .clk            (clk),
      .rst            (rst),
      .clear          (start_ok),
      .advance        (accept),
      .buf_len        (len_reg),
      .pre_count      (pre_reg),
      .base_addr      (base_reg),
      .wr_ptr         (wr_ptr),
      .win_start_calc (win_start_calc),
      .addr           (wr_addr)
   );

   always_comb begin
      state_next      = state_reg;
      base_next       = base_reg;
      len_next        = len_reg;
      pre_next        = pre_reg;
      post_next       = post_reg;
      pre_cnt_next    = pre_cnt_reg;
      post_cnt_next   = post_cnt_reg;
      trig_index_next = trig_index_reg;
      win_start_next  = win_start_reg;
      done_next       = done_reg;
      cfg_error_next  = cfg_error_reg;
      overflow_next   = overflow_reg;

      if (abort) begin
         state_next = ST_IDLE;
         done_next  = 1'b0;
      end else if (start_ok) begin
         base_next      = base_addr;
         len_next       = buf_len;
         pre_next       = pre_count;
         post_next      = post_count;
         pre_cnt_next   = '0;
         post_cnt_next  = '0;
         done_next      = 1'b0;
         overflow_next  = 1'b0;
         cfg_error_next = cfg_bad;
         if (cfg_bad) begin
            state_next = ST_IDLE;
         end else if (pre_count == '0) begin
            state_next = ST_ARMED;
         end else begin
            state_next = ST_PRE;
         end
      end else begin
         if (drop) begin
            overflow_next = 1'b1;
         end
         case (state_reg)
            ST_PRE: begin
               if (accept && (pre_cnt_reg < pre_reg)) begin
                  pre_cnt_next = pre_cnt_reg + 1'b1;
                  if (pre_cnt_next == pre_reg) begin
                     state_next = ST_ARMED;
                  end
               end
            end
            ST_ARMED: begin
               if (accept && trig_in) begin
                  trig_index_next = wr_ptr;
                  win_start_next  = win_start_calc;
                  post_cnt_next   = (post_reg == '0) ? '0 : CNT_WIDTH'(1);
                  if (post_reg < CNT_WIDTH'(2)) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (accept && (post_cnt_reg < post_reg)) begin
                  post_cnt_next = post_cnt_reg + 1'b1;
                  if (post_cnt_next == post_reg) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         base_reg       <= '0;
         len_reg        <= '0;
         pre_reg        <= '0;
         post_reg       <= '0;
         pre_cnt_reg    <= '0;
         post_cnt_reg   <= '0;
         trig_index_reg <= '0;
         win_start_reg  <= '0;
         done_reg       <= 1'b0;
         cfg_error_reg  <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         base_reg       <= base_next;
         len_reg        <= len_next;
         pre_reg        <= pre_next;
         post_reg       <= post_next;
         pre_cnt_reg    <= pre_cnt_next;
         post_cnt_reg   <= post_cnt_next;
         trig_index_reg <= trig_index_next;
         win_start_reg  <= win_start_next;
         done_reg       <= done_next;
         cfg_error_reg  <= cfg_error_next;
         overflow_reg   <= overflow_next;
      end
   end

   // Output register: data and address only change when a new sample is taken,
   // so they stay stable for the whole time the DMA stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_addr_reg  <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= in_data;
         out_addr_reg  <= wr_addr;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign out_addr   = out_addr_reg;
   assign trig_index = trig_index_reg;
   assign win_start  = win_start_reg;
   assign busy       = active;
   assign done       = done_reg;
   assign cfg_error  = cfg_error_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_acq_window_sequencer.sv
// Directed bench for acq_window_sequencer: normal run, wrap, trigger in PRE,
// backpressure, config errors, abort and reset.
module tb_acq_window_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] base_addr;
   logic [15:0] buf_len;
   logic [15:0] pre_count;
   logic [15:0] post_count;
   logic        in_data_valid;
   logic [15:0] in_data;
   logic        trig_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [31:0] out_addr;
   logic [15:0] trig_index;
   logic [15:0] win_start;
   logic        busy;
   logic        done;
   logic        cfg_error;
   logic        overflow;

   int passed = 0;
   int total  = 0;
   int wr_cnt = 0;
   int b      = 0;
   logic [31:0] wr_addr [0:255];

   acq_window_sequencer #(
      .DATA_WIDTH      (16),
      .MEMORY_ADDR_LEN (32),
      .CNT_WIDTH       (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .base_addr     (base_addr),
      .buf_len       (buf_len),
      .pre_count     (pre_count),
      .post_count    (post_count),
      .in_data_valid (in_data_valid),
      .in_data       (in_data),
      .trig_in       (trig_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_addr      (out_addr),
      .trig_index    (trig_index),
      .win_start     (win_start),
      .busy          (busy),
      .done          (done),
      .cfg_error     (cfg_error),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) begin
         wr_addr[wr_cnt[7:0]] <= out_addr;
         wr_cnt <= wr_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] ba, input logic [15:0] len,
                           input logic [15:0] pre, input logic [15:0] post);
      base_addr  = ba;
      buf_len    = len;
      pre_count  = pre;
      post_count = post;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic sample(input logic [15:0] d, input logic t);
      in_data_valid = 1'b1;
      in_data       = d;
      trig_in       = t;
      tick();
      in_data_valid = 1'b0;
      trig_in       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      base_addr = '0; buf_len = '0; pre_count = '0; post_count = '0;
      in_data_valid = 1'b0; in_data = '0; trig_in = 1'b0; out_ready = 1'b1;
      tick(); tick();

      // reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_error", cfg_error, 0);
      check("rst_overflow", overflow, 0);
      check("rst_out_addr", out_addr, 0);
      rst = 1'b0;
      tick();

      // normal run: buf 16, pre 4, post 4, trigger on sample 10; start in PRE ignored
      do_start(32'h1000, 16, 4, 4);
      check("norm_busy", busy, 1);
      b = wr_cnt;
      for (int i = 1; i <= 13; i++) begin
         if (i == 2) begin
            start = 1'b1;
            base_addr = 32'h9000;
         end
         sample(16'h0100 + 16'(i), i == 10);
         start = 1'b0;
         base_addr = 32'h1000;
         if (i == 9) check("norm_done_early", done, 0);
         if (i == 10) begin
            check("norm_trig_index", trig_index, 9);
            check("norm_win_start", win_start, 5);
         end
      end
      check("norm_done", done, 1);
      check("norm_busy_done", busy, 0);
      check("norm_last_addr", out_addr, 32'h1018);
      check("norm_last_data", out_data, 16'h010D);
      sample(16'h01FF, 1'b0);
      tick();
      check("norm_no_accept_in_done", out_valid, 0);
      check("norm_write_count", wr_cnt - b, 13);
      for (int k = 0; k < 13; k++) begin
         check("norm_addr", wr_addr[b + k], 32'h1000 + 32'(2 * k));
      end

      // wrap: buf 8, pre 3, post 3, trigger on sample 20
      do_start(32'h2000, 8, 3, 3);
      b = wr_cnt;
      for (int i = 1; i <= 22; i++) begin
         sample(16'h0200 + 16'(i), i == 20);
         if (i == 20) begin
            check("wrap_trig_index", trig_index, 3);
            check("wrap_win_start", win_start, 0);
         end
      end
      check("wrap_done", done, 1);
      tick();
      check("wrap_write_count", wr_cnt - b, 22);
      check("wrap_addr_s8", wr_addr[b + 7], 32'h200E);
      check("wrap_addr_s9", wr_addr[b + 8], 32'h2000);
      check("wrap_addr_s22", wr_addr[b + 21], 32'h200A);

      // trigger asserted during PRE is ignored; only sample 6 triggers
      do_start(32'h0000, 16, 4, 2);
      for (int i = 1; i <= 7; i++) begin
         sample(16'h0300 + 16'(i), (i <= 3) || (i == 6));
         if (i == 5) check("pretrig_not_done", done, 0);
         if (i == 6) begin
            check("pretrig_trig_index", trig_index, 5);
            check("pretrig_win_start", win_start, 1);
            check("pretrig_busy", busy, 1);
         end
      end
      check("pretrig_done", done, 1);

      // backpressure: three stalled cycles with continuous valid
      do_start(32'h3000, 16, 2, 8);
      b = wr_cnt;
      sample(16'h00A1, 1'b0);
      check("bp_first_addr", out_addr, 32'h3000);
      out_ready = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         sample(16'h00A0 + 16'(i), 1'b0);
         check("bp_stall_data", out_data, 16'h00A1);
         check("bp_stall_addr", out_addr, 32'h3000);
      end
      check("bp_overflow", overflow, 1);
      out_ready = 1'b1;
      sample(16'h00A5, 1'b0);
      check("bp_resume_data", out_data, 16'h00A5);
      check("bp_resume_addr", out_addr, 32'h3002);
      sample(16'h00A6, 1'b1);
      check("bp_trig_index", trig_index, 2);
      check("bp_win_start", win_start, 0);

      // abort in POST
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_overflow_sticky", overflow, 1);
      check("bp_write_count", wr_cnt - b, 3);

      // config errors and the legal boundary pre+post == buf_len
      do_start(32'h0000, 8, 5, 4);
      check("cfg_error_set", cfg_error, 1);
      check("cfg_overflow_cleared", overflow, 0);
      check("cfg_idle", busy, 0);
      sample(16'h0BAD, 1'b1);
      check("cfg_no_write", out_valid, 0);
      do_start(32'h0000, 8, 4, 4);
      check("cfg_boundary_ok", cfg_error, 0);
      check("cfg_boundary_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      do_start(32'h0000, 0, 0, 0);
      check("cfg_zero_len", cfg_error, 1);

      // pre 0, post 1: DONE right after the first triggered sample
      do_start(32'h4000, 8, 0, 1);
      check("p0_cfg_ok", cfg_error, 0);
      check("p0_armed_busy", busy, 1);
      sample(16'h00B1, 1'b0);
      check("p0_addr0", out_addr, 32'h4000);
      check("p0_not_done", done, 0);
      sample(16'h00B2, 1'b1);
      check("p0_done", done, 1);
      check("p0_busy", busy, 0);
      check("p0_trig_index", trig_index, 1);
      check("p0_win_start", win_start, 1);
      check("p0_addr1", out_addr, 32'h4002);
      tick();

      // start and abort together from DONE resolve as abort
      base_addr = 32'h0; buf_len = 16; pre_count = 4; post_count = 4;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("startabort_busy", busy, 0);
      check("startabort_done", done, 0);

      // reset in the middle of PRE
      do_start(32'h5000, 16, 4, 4);
      sample(16'h00C1, 1'b0);
      check("midpre_valid", out_valid, 1);
      rst = 1'b1;
      tick();
      check("midpre_rst_valid", out_valid, 0);
      check("midpre_rst_addr", out_addr, 0);
      check("midpre_rst_data", out_data, 0);
      check("midpre_rst_busy", busy, 0);
      check("midpre_rst_trig", trig_index, 0);
      check("midpre_rst_win", win_start, 0);
      check("midpre_rst_done", done, 0);
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
